// File: rtl/cpu_fetch_pkg.sv
// ============================================================================
// Module      : cpu_fetch_pkg
// Description : Shared FSM encodings, PC-source selects and branch helper
//               for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_REQ  = 2'b01,
        FS_ERR  = 2'b10
    } fetch_state_t;

    localparam logic [1:0] PC_S_INC  = 2'b00;
    localparam logic [1:0] PC_S_BR   = 2'b01;
    localparam logic [1:0] PC_S_F    = 2'b10;
    localparam logic [1:0] PC_S_HOLD = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Sign-extended 24-bit word offset, already scaled to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [23:0] imm);
        return {{6{imm[23]}}, imm, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_fetch_unit_pc_next_calc.sv
// ============================================================================
// Module      : pc_next_calc
// Description : Combinational next-PC selection (increment, branch, ALU, hold).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_calc
    import cpu_fetch_pkg::*;
(
    input  logic [1:0]  pc_s,
    input  logic [31:0] pc,
    input  logic [23:0] ir_imm,
    input  logic [31:0] f,
    output logic [31:0] pc_next
);

    logic [31:0] w_pc_inc;

    assign w_pc_inc = pc + 32'd4;

    always_comb begin
        pc_next = pc;
        case (pc_s)
            PC_S_INC:  pc_next = w_pc_inc;
            PC_S_BR:   pc_next = w_pc_inc + branch_offset(ir_imm);
            PC_S_F:    pc_next = f;
            default:   pc_next = pc;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_fetch_unit.sv
// ============================================================================
// Module      : cpu_fetch_unit
// Description : Owns PC and IR; fetches one instruction word per write_ir over
//               a req/ack handshake. Optional macro FETCH_ALIGN_CHECK_EN turns
//               a misaligned fetch into a fetch error instead of a request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_pc,
    input  logic [1:0]  pc_s,
    input  logic [31:0] F,
    input  logic        write_ir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic [31:0] PC,
    output logic        ir_valid,
    output logic        busy,
    output logic        fetch_err
);

    localparam int unsigned         WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    fetch_state_t      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       pend_pc_q, pend_pc_d;
    logic              pend_pc_v_q, pend_pc_v_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              ir_valid_q, ir_valid_d;

    logic [31:0]       w_pc_target;
    logic              w_pc_load;

    pc_next_calc u_pc_next_calc (
        .pc_s    (pc_s),
        .pc      (pc_q),
        .ir_imm  (ir_q[23:0]),
        .f       (F),
        .pc_next (w_pc_target)
    );

    assign w_pc_load = write_pc && (pc_s != PC_S_HOLD);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        pend_pc_d   = pend_pc_q;
        pend_pc_v_d = pend_pc_v_q;
        wait_cnt_d  = wait_cnt_q;
        ir_valid_d  = 1'b0;

        case (state_q)
            FS_IDLE: begin
                // A same-cycle write_pc lands first so the fetch uses the new PC.
                if (w_pc_load) begin
                    pc_d = w_pc_target;
                end
                if (write_ir) begin
                    wait_cnt_d = '0;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (pc_d[1:0] != 2'b00) begin
                        state_d = FS_ERR;
                    end else begin
                        state_d = FS_REQ;
                    end
`else
                    state_d = FS_REQ;
`endif
                end
            end

            FS_REQ: begin
                // PC must stay stable mid-request; park the target until ack.
                if (w_pc_load) begin
                    pend_pc_d   = w_pc_target;
                    pend_pc_v_d = 1'b1;
                end
                if (imem_ack) begin
                    ir_d        = imem_rdata;
                    ir_valid_d  = 1'b1;
                    state_d     = FS_IDLE;
                    wait_cnt_d  = '0;
                    if (pend_pc_v_d) begin
                        pc_d = pend_pc_d;
                    end
                    pend_pc_v_d = 1'b0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = FS_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            FS_ERR: begin
                state_d = FS_ERR;
            end

            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FS_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= 32'h0000_0000;
            pend_pc_q   <= 32'h0000_0000;
            pend_pc_v_q <= 1'b0;
            wait_cnt_q  <= '0;
            ir_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            pend_pc_q   <= pend_pc_d;
            pend_pc_v_q <= pend_pc_v_d;
            wait_cnt_q  <= wait_cnt_d;
            ir_valid_q  <= ir_valid_d;
        end
    end

    assign imem_req  = (state_q == FS_REQ);
    assign busy      = (state_q == FS_REQ);
    assign fetch_err = (state_q == FS_ERR);
    assign imem_addr = {pc_q[31:2], 2'b00};
    assign IR        = ir_q;
    assign PC        = pc_q;
    assign ir_valid  = ir_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_fetch_unit.sv
// ============================================================================
// Module      : tb_cpu_fetch_unit
// Description : Directed self-checking bench for cpu_fetch_unit with an IR
//               scoreboard; follows FETCH_ALIGN_CHECK_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_pc;
    logic [1:0]  pc_s;
    logic [31:0] F;
    logic        write_ir;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IR;
    logic [31:0] PC;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;

    int          n_assert  = 0;
    int          n_fail    = 0;
    int          valid_cnt = 0;
    int          n_pushed  = 0;
    logic [31:0] exp_ir_q[$];

    cpu_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .write_pc   (write_pc),
        .pc_s       (pc_s),
        .F          (F),
        .write_ir   (write_ir),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .IR         (IR),
        .PC         (PC),
        .ir_valid   (ir_valid),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller has already raised write_ir (and optionally write_pc).
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input int delay, input string tag);
        step();
        write_ir = 1'b0;
        write_pc = 1'b0;
        check({tag, "_req"}, {31'b0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr, addr);
        exp_ir_q.push_back(data);
        n_pushed++;
        for (int i = 0; i < delay; i++) begin
            step();
            check({tag, "_addr_hold"}, imem_addr, addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        check({tag, "_ir"}, IR, data);
    endtask

    // Scoreboard: every ir_valid pulse must match the oldest outstanding fetch.
    always begin
        @(posedge clk);
        #2;
        if (ir_valid === 1'b1) begin
            valid_cnt++;
            if (exp_ir_q.size() == 0)
                check("ir_valid_unexpected", {31'b0, ir_valid}, 32'd0);
            else
                check("ir_scoreboard", IR, exp_ir_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; write_pc = 1'b0; pc_s = 2'b00; F = '0;
        write_ir = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        step();
        step();
        check("rst_pc",    PC, 32'h0);
        check("rst_ir",    IR, 32'h0);
        check("rst_req",   {31'b0, imem_req},  32'd0);
        check("rst_valid", {31'b0, ir_valid},  32'd0);
        check("rst_err",   {31'b0, fetch_err}, 32'd0);
        check("rst_busy",  {31'b0, busy},      32'd0);
        rst = 1'b1;

        // Basic fetch, ack in the first REQ cycle
        write_ir = 1'b1;
        do_fetch(32'h0, 32'hE3A0_0001, 0, "t1");
        check("t1_valid", {31'b0, ir_valid}, 32'd1);
        check("t1_pc", PC, 32'h0);
        check("t1_req_drop", {31'b0, imem_req}, 32'd0);
        step();
        check("t1_valid_once", {31'b0, ir_valid}, 32'd0);
        check("t1_pulse_cnt", valid_cnt, 32'd1);

        // Branch and increment arithmetic
        write_pc = 1'b1; pc_s = 2'b10; F = 32'h10;
        step();
        write_pc = 1'b0;
        check("t2_pc_f", PC, 32'h10);
        write_ir = 1'b1;
        do_fetch(32'h10, 32'hEAFF_FFFE, 1, "t2");
        write_pc = 1'b1; pc_s = 2'b01;
        step();
        write_pc = 1'b0;
        check("t2_branch", PC, 32'h0000_000C);
        write_pc = 1'b1; pc_s = 2'b10; F = 32'h10;
        step();
        pc_s = 2'b00;
        step();
        write_pc = 1'b0;
        check("t2_inc", PC, 32'h0000_0014);
        write_pc = 1'b1; pc_s = 2'b11;
        step();
        write_pc = 1'b0;
        check("t2_hold", PC, 32'h0000_0014);

        // write_pc during REQ is deferred to the ack edge; last write wins
        write_ir = 1'b1;
        step();
        write_ir = 1'b0;
        check("t3_req", {31'b0, imem_req}, 32'd1);
        check("t3_addr", imem_addr, 32'h14);
        exp_ir_q.push_back(32'h1234_5678);
        n_pushed++;
        write_pc = 1'b1; pc_s = 2'b10; F = 32'h200;
        step();
        F = 32'h100; write_ir = 1'b1;
        step();
        write_pc = 1'b0;
        check("t3_pc_old", PC, 32'h14);
        check("t3_addr_hold", imem_addr, 32'h14);
        step();
        check("t3_pc_wait", PC, 32'h14);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0; write_ir = 1'b0;
        check("t3_pc_new", PC, 32'h100);
        check("t3_ir", IR, 32'h1234_5678);
        step();
        check("t3_no_queue", {31'b0, imem_req}, 32'd0);

        // PC wrap, then simultaneous write_pc + write_ir
        write_pc = 1'b1; pc_s = 2'b10; F = 32'hFFFF_FFFC;
        step();
        pc_s = 2'b00;
        step();
        write_pc = 1'b0;
        check("t4_wrap", PC, 32'h0);
        write_ir = 1'b1; write_pc = 1'b1; pc_s = 2'b10; F = 32'h40;
        do_fetch(32'h40, 32'hE1A0_0000, 0, "t4");
        check("t4_pc", PC, 32'h40);

        // Misaligned fetch
        write_pc = 1'b1; pc_s = 2'b10; F = 32'h102;
        step();
        write_pc = 1'b0;
        check("t5_pc", PC, 32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
        write_ir = 1'b1;
        step();
        write_ir = 1'b0;
        check("t5_no_req", {31'b0, imem_req}, 32'd0);
        check("t5_err", {31'b0, fetch_err}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("t5_err_clr", {31'b0, fetch_err}, 32'd0);
`else
        write_ir = 1'b1;
        do_fetch(32'h100, 32'hE280_0001, 2, "t5");
        check("t5_pc_low_bits", PC, 32'h102);
`endif

        // Ack timeout into ERR
        write_pc = 1'b1; pc_s = 2'b10; F = 32'h80;
        step();
        write_pc = 1'b0;
        write_ir = 1'b1;
        step();
        write_ir = 1'b0;
        check("t6_req", {31'b0, imem_req}, 32'd1);
        repeat (14) step();
        check("t6_busy_before", {31'b0, busy}, 32'd1);
        check("t6_err_before", {31'b0, fetch_err}, 32'd0);
        step();
        check("t6_err", {31'b0, fetch_err}, 32'd1);
        check("t6_req_drop", {31'b0, imem_req}, 32'd0);
        check("t6_busy", {31'b0, busy}, 32'd0);
        write_ir = 1'b1; write_pc = 1'b1; pc_s = 2'b10; F = 32'h300;
        step();
        step();
        write_ir = 1'b0; write_pc = 1'b0;
        check("t6_ignore_req", {31'b0, imem_req}, 32'd0);
        check("t6_ignore_pc", PC, 32'h80);
        check("t6_sticky", {31'b0, fetch_err}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("t6_rst_err", {31'b0, fetch_err}, 32'd0);
        check("t6_rst_pc", PC, 32'h0);
        check("t6_rst_ir", IR, 32'h0);

        // Reset mid-REQ drops the request, the in-flight ack and the pending PC
        write_ir = 1'b1;
        step();
        write_ir = 1'b0;
        check("t7_req", {31'b0, imem_req}, 32'd1);
        write_pc = 1'b1; pc_s = 2'b10; F = 32'h500;
        step();
        write_pc = 1'b0;
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        rst = 1'b1; imem_ack = 1'b0;
        check("t7_req_drop", {31'b0, imem_req}, 32'd0);
        check("t7_ir", IR, 32'h0);
        check("t7_valid", {31'b0, ir_valid}, 32'd0);
        check("t7_pc", PC, 32'h0);
        write_ir = 1'b1;
        do_fetch(32'h0, 32'hE3A0_0002, 0, "t7f");
        check("t7_pend_discarded", PC, 32'h0);

        step();
        step();
        check("sb_empty", exp_ir_q.size(), 32'd0);
        check("pulse_total", valid_cnt, n_pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
